// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: drives the fetch PC to a combinational instruction ROM,
// captures {Inst, PC} pairs into a prefetch FIFO and hands them to decode with a
// valid/ready handshake. A redirect flushes the FIFO and reloads the PC.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned-redirect halt + FetchErr).
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        Clk,
  input  logic        Clrn,
  output logic [31:0] Addr,
  input  logic [31:0] Inst,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutInst,
  output logic [31:0] OutPC,
  output logic        FetchErr
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);

  logic [31:0]     r_pc;
  logic [31:0]     r_fifo_inst [DEPTH];
  logic [31:0]     r_fifo_pc   [DEPTH];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;

  logic w_halt;
  logic w_push;
  logic w_pop;

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic {StFetch, StHalt} state_e;
  state_e r_state;
  state_e w_state_next;

  // FSM state register
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) r_state <= StFetch;
    else       r_state <= w_state_next;
  end

  // Any redirect decides the state: misaligned target halts, aligned target resumes
  always_comb begin
    w_state_next = r_state;
    if (Redirect) begin
      w_state_next = (RedirectPC[1:0] != 2'b00) ? StHalt : StFetch;
    end
  end

  assign w_halt   = (r_state == StHalt);
  assign FetchErr = w_halt;
`else
  assign w_halt   = 1'b0;
  assign FetchErr = 1'b0;
`endif

  assign Addr     = r_pc;
  assign OutValid = (r_count != '0) & ~w_halt;
  assign OutInst  = r_fifo_inst[r_rptr];
  assign OutPC    = r_fifo_pc[r_rptr];

  // Redirect blocks both ends; a full FIFO may still push when the head pops
  assign w_pop  = OutValid & OutReady & ~Redirect;
  assign w_push = ~Redirect & ~w_halt & ((r_count < DepthCnt) | w_pop);

  // Fetch PC, pointers and occupancy; redirect has priority over push/pop
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_pc    <= RESET_PC;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (Redirect) begin
      r_pc    <= RedirectPC;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc   <= r_pc + 32'd4;
        r_wptr <= r_wptr + PtrOne;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrOne;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntOne;
        2'b01:   r_count <= r_count - CntOne;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO payload storage; contents are qualified by the pointers so no reset needed
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_fifo_inst[r_wptr] <= Inst;
      r_fifo_pc[r_wptr]   <= r_pc;
    end
  end

endmodule
